// File: rtl/vsm_pkg.sv
// Shared constants for the VSM datapath: program-counter width and the
// default register reset value.
package vsm_pkg;

  localparam int VSM_PC_W = 4;

  // Widest legal dreg is 64 bits; narrower instances take the low bits.
  localparam logic [63:0] VSM_RST_VAL = 64'h0;

endpackage : vsm_pkg

// File: rtl/dreg.sv
// Clocked D register with complementary outputs, synchronous clear and load enable.
// Define DREG_ASSERT_EN to compile the built-in protocol checks.
module dreg
  import vsm_pkg::*;
#(
  parameter int               WIDTH   = 1,
  parameter logic [WIDTH-1:0] RST_VAL = VSM_RST_VAL[WIDTH-1:0]
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] qn
);

  // NOTE: non-blocking so a toggling stage (d = qn) samples the pre-edge value.
  always_ff @(posedge clk) begin
    if (rst) begin
      q <= RST_VAL;
    end else if (en) begin
      q <= d;
    end
  end

  // qn is derived, never stored, so it can never disagree with q.
  assign qn = ~q;

`ifdef DREG_ASSERT_EN
  logic seen_rst;

  always_ff @(posedge clk) begin
    if (rst) begin
      seen_rst <= 1'b1;
    end
  end

  a_qn_compl : assert property (@(posedge clk) qn === ~q)
    else $error("dreg: qn is not the complement of q");

  a_rst_val : assert property (@(posedge clk) rst |=> (q === RST_VAL))
    else $error("dreg: q differs from RST_VAL after a reset edge");

  a_hold : assert property (@(posedge clk)
    disable iff (seen_rst !== 1'b1) (!rst && !en) |=> $stable(q))
    else $error("dreg: q changed while en was low");

  always_comb begin
    if (seen_rst === 1'b1) begin
      a_no_x : assert (!$isunknown({clk, rst, en}))
        else $error("dreg: X/Z on clk, rst or en after reset");
    end
  end
`endif

endmodule : dreg

// File: tb/tb_dreg.sv
// Directed self-checking bench for dreg: reset, load/hold, reset priority,
// single-bit toggle and a 4-stage ripple counter built from WIDTH=1 cells.
module tb_dreg;
  import vsm_pkg::*;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       en  = 1'b1;
  logic [3:0] d   = 4'hF;
  logic [7:0] d8  = 8'h3C;
  logic       tog_en = 1'b1;

  logic [3:0] q4, qn4;
  logic [7:0] q8, qn8;
  logic       tog_q, tog_qn;

  logic rc_clk0 = 1'b0;
  logic rc_rst  = 1'b0;
  logic rc_sync = 1'b1;
  wire [VSM_PC_W-1:0] rc_q, rc_qn, rc_clk;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dreg #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst), .en(en), .d(d), .q(q4), .qn(qn4)
  );

  dreg #(.WIDTH(8), .RST_VAL(8'hA5)) u_dut8 (
    .clk(clk), .rst(rst), .en(en), .d(d8), .q(q8), .qn(qn8)
  );

  dreg #(.WIDTH(1)) u_tog (
    .clk(clk), .rst(rst), .en(tog_en), .d(tog_qn), .q(tog_q), .qn(tog_qn)
  );

  // During a ripple reset every stage is clocked directly so each sees an edge.
  assign rc_clk[0] = rc_clk0;
  for (genvar k = 1; k < VSM_PC_W; k++) begin : g_rc_clk
    assign rc_clk[k] = rc_sync ? rc_clk0 : rc_q[k-1];
  end

  for (genvar k = 0; k < VSM_PC_W; k++) begin : g_rc
    dreg #(.WIDTH(1)) u_rc (
      .clk(rc_clk[k]), .rst(rc_rst), .en(1'b1), .d(rc_qn[k]),
      .q(rc_q[k]), .qn(rc_qn[k])
    );
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp)
      else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  task automatic rc_pulse();
    rc_clk0 = 1'b1;
    #5;
    rc_clk0 = 1'b0;
    #5;
  endtask

  task automatic rc_reset();
    rc_rst  = 1'b1;
    rc_sync = 1'b1;
    #1;
    rc_pulse();
    rc_rst  = 1'b0;
    rc_sync = 1'b0;
    #1;
  endtask

  initial begin
    logic [3:0]  rc_exp;
    logic [15:0] visited;

    // Reset for two edges with en=1 and d all-ones: reset must dominate.
    tick(1);
    check("rst1_q4", 64'(q4), 64'h0);
    check("rst1_qn4", 64'(qn4), 64'hF);
    check("rst1_q8", 64'(q8), 64'hA5);
    check("rst1_qn8", 64'(qn8), 64'h5A);
    check("rst1_tog", 64'(tog_q), 64'h0);
    tick(1);
    check("rst2_q4", 64'(q4), 64'h0);
    check("rst2_qn4", 64'(qn4), 64'hF);
    check("rst2_q8", 64'(q8), 64'hA5);

    // Load then hold.
    rst = 1'b0; tog_en = 1'b0; en = 1'b1; d = 4'hA;
    tick(1);
    check("load_q4", 64'(q4), 64'hA);
    check("load_qn4", 64'(qn4), 64'h5);
    check("load_q8", 64'(q8), 64'h3C);
    en = 1'b0; d = 4'h3; d8 = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check("hold_q4", 64'(q4), 64'hA);
    end
    check("hold_q8", 64'(q8), 64'h3C);
    d = 4'bxxxx;
    tick(1);
    check("hold_x_q4", 64'(q4), 64'hA);
    check("hold_x_qn4", 64'(qn4), 64'h5);

    // Reset and load on the same edge, then release.
    rst = 1'b1; en = 1'b1; d = 4'hF; d8 = 8'h3C;
    tick(1);
    check("simul_q4", 64'(q4), 64'h0);
    check("simul_q8", 64'(q8), 64'hA5);
    rst = 1'b0;
    tick(1);
    check("post_q4", 64'(q4), 64'hF);
    check("post_qn4", 64'(qn4), 64'h0);
    check("post_q8", 64'(q8), 64'h3C);

    // Divide-by-2 toggle.
    check("tog_start", 64'(tog_q), 64'h0);
    tog_en = 1'b1;
    for (int i = 0; i < 6; i++) begin
      tick(1);
      check("tog_q", 64'(tog_q), 64'((i % 2) == 0));
      check("tog_qn", 64'(tog_qn), 64'((i % 2) != 0));
    end

    // Ripple counter: rising-q clocking makes it count down from 0.
    rc_reset();
    check("rc_rst", 64'(rc_q), 64'h0);
    rc_exp  = 4'h0;
    visited = 16'h0;
    for (int i = 0; i < 16; i++) begin
      rc_pulse();
      rc_exp = rc_exp - 4'h1;
      visited[rc_q] = 1'b1;
      check("rc_count", 64'(rc_q), 64'(rc_exp));
    end
    check("rc_visited", 64'(visited), 64'hFFFF);
    check("rc_wrap", 64'(rc_q), 64'h0);

    repeat (5) rc_pulse();
    check("rc_mid", 64'(rc_q), 64'hB);
    rc_reset();
    check("rc_mid_rst", 64'(rc_q), 64'h0);
    rc_pulse();
    check("rc_after_rst", 64'(rc_q), 64'hF);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule : tb_dreg
